// File: rtl/sevenseg_scanner.sv
// Eight-digit multiplexed seven-segment driver with PWM dimming.
// Ports: clk, rst (sync, active-high); digits/blank/dp/bright inputs are
// snapshotted once per frame; segs_n/an_n/dp_n are registered active-low
// drives; frame_tick pulses in the first output cycle of each frame.
module sevenseg_scanner #(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  blank,
  input  logic [7:0]  dp,
  input  logic [2:0]  bright,
  output logic [6:0]  segs_n,
  output logic [7:0]  an_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int SUB_CYCLES = DIGIT_CYCLES / 8;
  localparam int SW = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB_CYCLES - 1);

  logic [SW-1:0] sub_q, sub_d;
  logic [2:0]    phase_q, phase_d;
  logic [2:0]    digit_q, digit_d;

  logic [31:0]   snap_digits_q, snap_digits_d;
  logic [7:0]    snap_blank_q, snap_blank_d;
  logic [7:0]    snap_dp_q, snap_dp_d;
  logic [2:0]    snap_bright_q, snap_bright_d;

  logic [6:0]    segs_n_q, segs_n_d;
  logic [7:0]    an_n_q, an_n_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_tick_q, frame_tick_d;

  logic          sub_wrap;
  logic          phase_wrap;
  logic          frame_last;
  logic          lit;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  always_comb begin
    sub_wrap   = (sub_q == SUB_LAST);
    phase_wrap = sub_wrap && (phase_q == 3'd7);
    frame_last = phase_wrap && (digit_q == 3'd7);

    sub_d   = sub_wrap ? '0 : sub_q + 1'b1;
    phase_d = sub_wrap ? phase_q + 3'd1 : phase_q;
    digit_d = phase_wrap ? digit_q + 3'd1 : digit_q;

    // Capture on the last counter state so a new frame starts clean.
    snap_digits_d = frame_last ? digits : snap_digits_q;
    snap_blank_d  = frame_last ? blank  : snap_blank_q;
    snap_dp_d     = frame_last ? dp     : snap_dp_q;
    snap_bright_d = frame_last ? bright : snap_bright_q;

    nibble = snap_digits_q[{digit_q, 2'b00} +: 4];
    lit    = (phase_q <= snap_bright_q) && !snap_blank_q[digit_q];

    seg_dec = 7'h7F;
    unique case (nibble)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
    endcase

    segs_n_d = 7'h7F;
    an_n_d   = 8'hFF;
    dp_n_d   = 1'b1;
    if (lit) begin
      segs_n_d = seg_dec;
      an_n_d   = ~(8'd1 << digit_q);
      dp_n_d   = ~snap_dp_q[digit_q];
    end

    frame_tick_d = (digit_q == 3'd0) && (phase_q == 3'd0)
                && (sub_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q         <= '0;
      phase_q       <= '0;
      digit_q       <= '0;
      snap_digits_q <= '0;
      snap_blank_q  <= 8'hFF;
      snap_dp_q     <= '0;
      snap_bright_q <= '0;
      segs_n_q      <= 7'h7F;
      an_n_q        <= 8'hFF;
      dp_n_q        <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      sub_q         <= sub_d;
      phase_q       <= phase_d;
      digit_q       <= digit_d;
      snap_digits_q <= snap_digits_d;
      snap_blank_q  <= snap_blank_d;
      snap_dp_q     <= snap_dp_d;
      snap_bright_q <= snap_bright_d;
      segs_n_q      <= segs_n_d;
      an_n_q        <= an_n_d;
      dp_n_q        <= dp_n_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign segs_n     = segs_n_q;
  assign an_n       = an_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule
